timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 13 +
 rtl/timer_ctrl.sv | 153 +++++++++++++++
 tb/tb_timer_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Local-bus interface for timer_ctrl: single-cycle request, one-cycle rdy reply.
interface timer_ctrl_if;
  logic [7:0] addr;
  logic       cs;
  logic       req;
  logic       rnw;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rdy;

  modport master (output addr, cs, req, rnw, wr_data, input rd_data, rdy);
  modport slave  (input addr, cs, req, rnw, wr_data, output rd_data, rdy);
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled 16-bit down-counter with auto-reload, sticky EXP flag
// and a local-bus register file. Optional macro TIMER_CTRL_IRQ_EN adds CTRL
// bit2 (IE) and a registered irq = EXP && IE; without it irq is tied low.
module timer_ctrl #(
  parameter logic [7:0] RESET_PRESCALE = 8'd0
) (
  input  logic         clk,
  input  logic         reset_,
  timer_ctrl_if.slave  bus,
  output logic         irq
);
  localparam logic [7:0] A_CTRL     = 8'h00;
  localparam logic [7:0] A_PRESCALE = 8'h01;
  localparam logic [7:0] A_RLD_LO   = 8'h02;
  localparam logic [7:0] A_RLD_HI   = 8'h03;
  localparam logic [7:0] A_CNT_LO   = 8'h04;
  localparam logic [7:0] A_CNT_HI   = 8'h05;
  localparam logic [7:0] A_STATUS   = 8'h06;

  logic        r_en, r_auto;
  logic [7:0]  r_pre;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [7:0]  r_pcnt;
  logic [7:0]  r_shadow;
  logic        r_exp;
  logic        r_rdy;
  logic [7:0]  r_rdata;

  logic        w_acc, w_wr, w_rd, w_wr_ctrl, w_en_rise;
  logic        w_tick, w_expire, w_clr, w_ie;
  logic [7:0]  w_rmux;

  // A new transfer is not taken while the previous reply is still on the bus,
  // so each request yields exactly one isolated rdy pulse.
  assign w_acc     = bus.cs && bus.req && !r_rdy;
  assign w_wr      = w_acc && !bus.rnw;
  assign w_rd      = w_acc && bus.rnw;
  assign w_wr_ctrl = w_wr && (bus.addr == A_CTRL);
  assign w_en_rise = w_wr_ctrl && bus.wr_data[0] && !r_en;
  assign w_tick    = r_en && (r_pcnt == r_pre);
  assign w_expire  = w_tick && (r_count == 16'h0000);
  assign w_clr     = w_wr && (bus.addr == A_STATUS) && bus.wr_data[0];

`ifdef TIMER_CTRL_IRQ_EN
  logic r_ie;
  logic r_irq;

  // Interrupt enable bit lives in CTRL bit2.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)        r_ie <= 1'b0;
    else if (w_wr_ctrl) r_ie <= bus.wr_data[2];
  end

  // irq follows the registered EXP flag by one cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_irq <= 1'b0;
    else         r_irq <= r_exp && r_ie;
  end

  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
  assign irq  = 1'b0;
`endif

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    w_rmux = 8'h00;
    case (bus.addr)
      A_CTRL:     w_rmux = {5'b0, w_ie, r_auto, r_en};
      A_PRESCALE: w_rmux = r_pre;
      A_RLD_LO:   w_rmux = r_reload[7:0];
      A_RLD_HI:   w_rmux = r_reload[15:8];
      A_CNT_LO:   w_rmux = r_count[7:0];
      A_CNT_HI:   w_rmux = r_shadow;
      A_STATUS:   w_rmux = {7'b0, r_exp};
      default:    w_rmux = 8'h00;
    endcase
  end

  // Bus reply: rdy and rd_data are valid only in the cycle after acceptance.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rdy   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_rdy   <= w_acc;
      r_rdata <= w_rd ? w_rmux : 8'h00;
    end
  end

  assign bus.rdy     = r_rdy;
  assign bus.rd_data = r_rdata;

  // Plain configuration registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_pre    <= RESET_PRESCALE;
      r_reload <= 16'h0000;
      r_auto   <= 1'b0;
    end else if (w_wr) begin
      case (bus.addr)
        A_CTRL:     r_auto          <= bus.wr_data[1];
        A_PRESCALE: r_pre           <= bus.wr_data;
        A_RLD_LO:   r_reload[7:0]   <= bus.wr_data;
        A_RLD_HI:   r_reload[15:8]  <= bus.wr_data;
        default:    ;
      endcase
    end
  end

  // EN: software-controlled, self-clears on a one-shot expiry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_en <= 1'b0;
    else begin
      if (w_wr_ctrl)             r_en <= bus.wr_data[0];
      if (w_expire && !r_auto)   r_en <= 1'b0;
    end
  end

  // Counter and prescaler; both hold while EN=0. RELOAD only reaches the
  // count on EN rising or on an auto-reload expiry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_count <= 16'h0000;
      r_pcnt  <= 8'h00;
    end else if (w_en_rise) begin
      r_count <= r_reload;
      r_pcnt  <= 8'h00;
    end else if (r_en) begin
      r_pcnt <= w_tick ? 8'h00 : r_pcnt + 8'd1;
      if (w_tick) begin
        if (r_count != 16'h0000) r_count <= r_count - 16'd1;
        else if (r_auto)         r_count <= r_reload;
        else                     r_count <= 16'h0000;
      end
    end
  end

  // High-byte snapshot taken on a COUNT_LO read for a coherent 16-bit read.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                                  r_shadow <= 8'h00;
    else if (w_rd && (bus.addr == A_CNT_LO))      r_shadow <= r_count[15:8];
  end

  // Sticky EXP; a same-cycle expiry wins over write-1-to-clear.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_exp <= 1'b0;
    else         r_exp <= w_expire || (r_exp && !w_clr);
  end
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed, table-driven bench for timer_ctrl.
module tb_timer_ctrl;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic irq;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;

  timer_ctrl_if bus ();
  timer_ctrl dut (.clk(clk), .reset_(reset_), .bus(bus), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef TIMER_CTRL_IRQ_EN
  localparam logic [7:0] CTRL_FE  = 8'h06;
  localparam logic [7:0] CTRL_07  = 8'h07;
  localparam logic       IRQ_EXP  = 1'b1;
`else
  localparam logic [7:0] CTRL_FE  = 8'h02;
  localparam logic [7:0] CTRL_07  = 8'h03;
  localparam logic       IRQ_EXP  = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       rnw;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];
  logic [7:0] rst_addr [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic xfer(input logic [7:0] a, input logic rd, input logic [7:0] wd,
                      output logic [7:0] rdat);
    @(negedge clk);
    bus.cs = 1'b1; bus.req = 1'b1; bus.addr = a; bus.rnw = rd; bus.wr_data = wd;
    @(negedge clk);
    bus.cs = 1'b0; bus.req = 1'b0;
    chk("rdy", {15'b0, bus.rdy}, 16'h1);
    rdat = bus.rd_data;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    xfer(a, 1'b0, d, r);
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    xfer(a, 1'b1, 8'h00, r);
    chk(nm, {8'h00, r}, {8'h00, exp});
  endtask

  task automatic wait_exp(output int t);
    int n;
    n = 0;
    while (!dut.r_exp && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!dut.r_exp) chk("exp_timeout", 16'h0, 16'h1);
    t = cyc;
  endtask

  task automatic chk_reset_regs();
    foreach (rst_addr[i]) rd("reset_reg", rst_addr[i], 8'h00);
    chk("reset_irq", {15'b0, irq}, 16'h0);
  endtask

  initial begin
    int t0, t1;
    logic [7:0] r;

    tbl[0]  = '{8'h01, 1'b0, 8'hA5, 8'h00};
    tbl[1]  = '{8'h01, 1'b1, 8'h00, 8'hA5};
    tbl[2]  = '{8'h02, 1'b0, 8'h12, 8'h00};
    tbl[3]  = '{8'h03, 1'b0, 8'h34, 8'h00};
    tbl[4]  = '{8'h02, 1'b1, 8'h00, 8'h12};
    tbl[5]  = '{8'h03, 1'b1, 8'h00, 8'h34};
    tbl[6]  = '{8'h00, 1'b0, 8'hFE, 8'h00};
    tbl[7]  = '{8'h00, 1'b1, 8'h00, CTRL_FE};
    tbl[8]  = '{8'h07, 1'b0, 8'h77, 8'h00};
    tbl[9]  = '{8'h07, 1'b1, 8'h00, 8'h00};
    tbl[10] = '{8'h06, 1'b0, 8'h01, 8'h00};
    tbl[11] = '{8'h06, 1'b1, 8'h00, 8'h00};
    tbl[12] = '{8'h04, 1'b0, 8'hAA, 8'h00};
    tbl[13] = '{8'h04, 1'b1, 8'h00, 8'h00};
    tbl[14] = '{8'h00, 1'b0, 8'h00, 8'h00};
    tbl[15] = '{8'h00, 1'b1, 8'h00, 8'h00};
    rst_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h3F};

    bus.cs = 1'b0; bus.req = 1'b0; bus.rnw = 1'b0; bus.addr = 8'h00; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {15'b0, bus.rdy}, 16'h0);
    chk("rst_rdata", {8'h00, bus.rd_data}, 16'h0);
    reset_ = 1'b1;
    chk_reset_regs();

    // Register file vectors.
    foreach (tbl[i]) begin
      xfer(tbl[i].addr, tbl[i].rnw, tbl[i].wdata, r);
      chk($sformatf("vec%0d", i), {8'h00, r}, {8'h00, tbl[i].exp});
    end

    // One-shot countdown 3,2,1,0 then expiry and EN self-clear.
    wr(8'h01, 8'h00); wr(8'h02, 8'h03); wr(8'h03, 8'h00);
    wr(8'h00, 8'h01);
    chk("cnt3", dut.r_count, 16'd3);
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      chk($sformatf("cnt%0d", k), dut.r_count, 16'(k));
    end
    chk("exp_pre", {15'b0, dut.r_exp}, 16'h0);
    @(negedge clk);
    chk("exp_set", {15'b0, dut.r_exp}, 16'h1);
    chk("cnt_hold", dut.r_count, 16'h0);
    rd("en_clr", 8'h00, 8'h00);
    rd("status1", 8'h06, 8'h01);

    // Auto-reload period: (4+1)*(2+1) = 15 cycles.
    wr(8'h06, 8'h01);
    wr(8'h01, 8'h04); wr(8'h02, 8'h02);
    wr(8'h00, 8'h03);
    t0 = cyc;
    wait_exp(t1);
    chk("first_exp", 16'(t1 - t0), 16'd15);
    for (int j = 0; j < 2; j++) begin
      t0 = t1;
      wr(8'h06, 8'h01);
      rd("exp_cleared", 8'h06, 8'h00);
      wait_exp(t1);
      chk("period", 16'(t1 - t0), 16'd15);
    end
    rd("exp_again", 8'h06, 8'h01);
    wr(8'h00, 8'h00); wr(8'h06, 8'h01);
    rd("stopped_clr", 8'h06, 8'h00);

    // Clear on the exact expiry cycle: expiry must win.
    wr(8'h01, 8'h00); wr(8'h02, 8'h02);
    wr(8'h00, 8'h01);
    @(negedge clk);
    wr(8'h06, 8'h01);
    rd("exp_vs_clr", 8'h06, 8'h01);
    wr(8'h06, 8'h01);
    rd("w1c", 8'h06, 8'h00);

    // Coherent 16-bit read across a low-byte wrap 0x0100 -> 0x00FF.
    wr(8'h01, 8'h02); wr(8'h02, 8'h00); wr(8'h03, 8'h01);
    wr(8'h00, 8'h01);
    rd("cnt_lo_wrap", 8'h04, 8'h00);
    rd("cnt_hi_shadow", 8'h05, 8'h01);
    rd("cnt_lo_ff", 8'h04, 8'hFF);
    rd("cnt_hi_00", 8'h05, 8'h00);
    wr(8'h00, 8'h00);

    // Unmapped read: one isolated rdy, zero data.
    @(negedge clk);
    bus.cs = 1'b1; bus.req = 1'b1; bus.addr = 8'h3F; bus.rnw = 1'b1;
    chk("unm_rdy_pre", {15'b0, bus.rdy}, 16'h0);
    @(negedge clk);
    bus.cs = 1'b0; bus.req = 1'b0;
    chk("unm_rdy", {15'b0, bus.rdy}, 16'h1);
    chk("unm_data", {8'h00, bus.rd_data}, 16'h0);
    @(negedge clk);
    chk("unm_rdy_post", {15'b0, bus.rdy}, 16'h0);

    // Frozen count; read-only writes ignored.
    wr(8'h01, 8'hFF); wr(8'h02, 8'h05); wr(8'h03, 8'h01);
    wr(8'h00, 8'h01); wr(8'h00, 8'h00);
    wr(8'h04, 8'h55); wr(8'h05, 8'h66);
    rd("ro_lo", 8'h04, 8'h05);
    rd("ro_hi", 8'h05, 8'h01);
    // RELOAD write while running does not touch the count.
    wr(8'h00, 8'h01); wr(8'h02, 8'h44);
    rd("rld_no_effect", 8'h04, 8'h05);
    wr(8'h00, 8'h00);

    // irq follows EXP by one cycle (tied low without the option).
    wr(8'h06, 8'h01);
    wr(8'h01, 8'h00); wr(8'h02, 8'h01); wr(8'h03, 8'h00);
    wr(8'h00, 8'h07);
    wait_exp(t1);
    chk("irq_lag", {15'b0, irq}, 16'h0);
    @(negedge clk);
    chk("irq_rise", {15'b0, irq}, {15'b0, IRQ_EXP});
    rd("ctrl_ie", 8'h00, CTRL_07);

    // Reset while counting.
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    chk("rst_irq_async", {15'b0, irq}, 16'h0);
    chk("rst_cnt_async", dut.r_count, 16'h0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    chk_reset_regs();

    // Reset during an in-flight request: no rdy after release.
    @(negedge clk);
    bus.cs = 1'b1; bus.req = 1'b1; bus.addr = 8'h00; bus.rnw = 1'b1;
    #2 reset_ = 1'b0;
    @(negedge clk);
    bus.cs = 1'b0; bus.req = 1'b0;
    reset_ = 1'b1;
    chk("abort_rdy0", {15'b0, bus.rdy}, 16'h0);
    @(negedge clk);
    chk("abort_rdy1", {15'b0, bus.rdy}, 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
